uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receiver (8N1, LSB first, idle-high line) for the Arty echo design. Takes the board's serial input pin, synchronises it to `CLK`, recovers one byte per frame by mid-bit sampling, and presents it on a valid/ack handshake. It is the receive-side counterpart of the existing UART transmit controller, uses the same bit-period convention, and feeds the echo/demo logic.

## Interface
- `CLKS_PER_BIT`, default 10416: `CLK` cycles per bit (100 MHz, 9600 baud); must be ≥ 4.
- `CLK`  input  1  system clock; all logic on the rising edge.
- `RST`  input  1  synchronous reset, active high.
- `UART_RX`  input  1  asynchronous serial line from the pin; idles high.
- `rx_data`  output  8  last accepted byte; valid while `rx_valid` = 1.
- `rx_valid`  output  1  level; high from byte delivery until the consumer acks it.
- `rx_ack`  input  1  consumer has taken `rx_data`; sampled only while `rx_valid` = 1.
- `frame_err`  output  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  output  1  sticky; a completed byte was dropped because `rx_valid` was still high.
- `busy`  output  1  high in every state except IDLE.

## Operation
- Input sync: two flops, both reset to 1. All decisions use the second flop, `rx_s`.
- Bit counter: width is the ceiling of log2(`CLKS_PER_BIT`). It clears on every state entry and after every sample. Bit index is 3 bits. Shift register is 8 bits and shifts right, so the first data bit lands in bit 0 after eight shifts.
- States (reset → IDLE):
  - IDLE: if `rx_s` = 0, go to START.
  - START: when the counter reaches `CLKS_PER_BIT/2 - 1` (integer divide), sample `rx_s`. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with no flags.
  - DATA: when the counter reaches `CLKS_PER_BIT - 1`, sample `rx_s` into the shift register. After the 8th sample, go to STOP.
  - STOP: when the counter reaches `CLKS_PER_BIT - 1`, sample `rx_s`.
    - If 1, deliver the byte and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. This keeps a break condition from being decoded as 0x00 frames.
- Delivery:
  - If `rx_valid` = 0: load `rx_data` and set `rx_valid` = 1.
  - If `rx_valid` = 1 and `rx_ack` = 0 that cycle: keep `rx_data` unchanged, set `overrun`.
  - If `rx_valid` = 1 and `rx_ack` = 1 in the same cycle: load the new byte, keep `rx_valid` = 1, leave `overrun` unchanged.
- Ack without delivery: clears `rx_valid` and `overrun` on the next edge. `rx_ack` while `rx_valid` = 0 has no effect.
- Reset mid-frame: the partial byte is discarded and no flags are raised.

## Timing
- Reset values: `rx_data` = 0x00; `rx_valid`, `frame_err`, `overrun` = 0; `busy` = 0; state = IDLE; sync flops = 1.
- Edge detection: a falling edge on `UART_RX` reaches `rx_s` 2 cycles later. START is entered on the following edge.
- Sample points, counted from START entry:
  - start-bit check at `CLKS_PER_BIT/2` cycles;
  - data bit k (k = 0..7) at `CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT` cycles;
  - stop bit at `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT` cycles.
- `rx_valid` rises, or `frame_err` pulses, on the edge after the stop sample. `busy` falls on that same edge.
- Back-to-back frames: IDLE can detect a new start bit on the first cycle after the stop sample. The receiver keeps up with continuous traffic at line rate.
- `rx_ack` → `rx_valid` low: 1 cycle.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 and drive ideal 16-cycle bits.
- Send 0x41 → `rx_valid` rises 2 + 1 + 8 + 144 cycles after the start edge, with `rx_data` = 0x41. Ack it → `rx_valid` = 0 one cycle later.
- Send "ARTY A7\n" back to back, acking each byte within 10 cycles → exactly 8 deliveries (0x41 0x52 0x54 0x59 0x20 0x41 0x37 0x0A); `overrun` and `frame_err` stay 0.
- 5-cycle low glitch on an idle line → `busy` pulses, then IDLE; no `rx_valid`, no `frame_err`.
- Frame 0x55 with a low stop bit, line held low 40 more cycles → one `frame_err` pulse and no `rx_valid`. No byte until the line goes high; a following 0x41 is then received correctly.
- Send 0x11 then 0x22 without ack → `rx_data` = 0x11 and `overrun` = 1. Ack → both clear. Then ack in the same cycle as the 0x33 delivery → `rx_data` = 0x33, `rx_valid` stays 1, `overrun` = 0.
- Assert `RST` during data bit 4 of a frame → all outputs return to reset values. The next clean 0xA5 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// =====================================================================
// Module  : uart_rx_ctrl
// Purpose : 8N1 UART receiver, mid-bit sampling, byte on valid/ack.
// Rev     : 1.0  initial release
// =====================================================================
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       UART_RX,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_sync1;
   logic               r_rx_s;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               w_cnt_clr;
   logic               w_shift;
   logic               w_deliver;
   logic               w_stop_bad;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= UART_RX;
         r_rx_s  <= r_sync1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_shift     = 1'b0;
      w_deliver   = 1'b0;
      w_stop_bad  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_clr = 1'b1;
            if (!r_rx_s) w_state_nxt = S_START;
         end
         S_START: begin
            if (r_cnt == c_HALF_LAST) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == c_BIT_LAST) begin
               w_cnt_clr = 1'b1;
               w_shift   = 1'b1;
               if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (r_cnt == c_BIT_LAST) begin
               w_cnt_clr   = 1'b1;
               w_deliver   = r_rx_s;
               w_stop_bad  = !r_rx_s;
               w_state_nxt = r_rx_s ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            // A held-low line (break) must not be decoded as a stream of 0x00 frames
            w_cnt_clr = 1'b1;
            if (r_rx_s) w_state_nxt = S_IDLE;
         end
         default: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST || w_cnt_clr) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         if (r_state == S_IDLE) r_bit_idx <= 3'd0;
         else if (w_shift)      r_bit_idx <= r_bit_idx + 3'd1;
         if (w_shift) r_shift <= {r_rx_s, r_shift[7:1]};
      end
   end

   // An ack arriving with a new byte lets that byte replace the old one
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= w_stop_bad;
         if (w_deliver) begin
            if (!rx_valid || rx_ack) begin
               rx_data  <= r_shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

   assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// =====================================================================
// Module  : tb_uart_rx_ctrl
// Purpose : Directed bench for uart_rx_ctrl with a frame-timeline model.
// Rev     : 1.0  initial release
// =====================================================================
module tb_uart_rx_ctrl;

   localparam int C      = 16;
   localparam int H      = C / 2;
   localparam int LINE_N = 8192;

   logic       CLK;
   logic       RST;
   logic       UART_RX;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx_ctrl #(.CLKS_PER_BIT(C)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .UART_RX   (UART_RX),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ack    (rx_ack),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Model: edge n acts on the line as it was at edge n-2 (two sync stages);
   // sample instants are fixed offsets from the frame's START entry edge.
   int         cyc = 0;
   bit         line [0:LINE_N-1];
   int         m_last_rst = 0;
   bit         m_in_frame = 0;
   bit         m_wait_high = 0;
   int         m_start = 0;
   logic [7:0] m_bits = 8'h00;
   logic [7:0] e_data = 8'h00;
   bit         e_valid = 0;
   bit         e_ferr = 0;
   bit         e_ovr = 0;
   bit         e_busy = 0;

   always @(posedge CLK) begin : model
      int n, s, t;
      bit v, fr, wh, val, ovr, ferr, deliver;
      logic [7:0] dat, bits;
      n = cyc + 1;
      fr = m_in_frame; wh = m_wait_high; s = m_start; bits = m_bits;
      dat = e_data; val = e_valid; ovr = e_ovr; ferr = 0; deliver = 0;
      if (n < LINE_N) line[n] <= UART_RX;
      if (RST) begin
         fr = 0; wh = 0; dat = 8'h00; val = 0; ovr = 0;
         m_last_rst <= n;
      end else begin
         v = (n - 2 > m_last_rst) ? line[n-2] : 1'b1;
         if (fr) begin
            t = n - s;
            if (t == H) begin
               if (v) fr = 0;
            end else if (t > H && t < H + 9*C && ((t - H) % C) == 0) begin
               bits[(t - H) / C - 1] = v;
            end else if (t == H + 9*C) begin
               fr = 0;
               if (v) deliver = 1;
               else begin ferr = 1; wh = 1; end
            end
         end else if (wh) begin
            if (v) wh = 0;
         end else if (!v) begin
            fr = 1;
            s = n;
         end
         if (deliver) begin
            if (!val || rx_ack) begin dat = bits; val = 1; end
            else ovr = 1;
         end else if (val && rx_ack) begin
            val = 0; ovr = 0;
         end
      end
      cyc         <= n;
      m_in_frame  <= fr;
      m_wait_high <= wh;
      m_start     <= s;
      m_bits      <= bits;
      e_data      <= dat;
      e_valid     <= val;
      e_ovr       <= ovr;
      e_ferr      <= ferr;
      e_busy      <= fr || wh;
   end

   always @(negedge CLK) begin
      if (cyc > 0)
         chk("outputs{data,valid,ferr,ovr,busy}",
             32'({rx_data, rx_valid, frame_err, overrun, busy}),
             32'({e_data, e_valid, e_ferr, e_ovr, e_busy}));
   end

   // Observation log used by the literal checks
   logic [7:0] rise_data [$];
   int         rise_cyc  [$];
   bit         prev_valid = 0;
   int         ferr_cnt = 0;
   int         busy_cnt = 0;
   int         ovr_cnt = 0;

   always @(negedge CLK) begin
      if (rx_valid === 1'b1 && !prev_valid) begin
         rise_data.push_back(rx_data);
         rise_cyc.push_back(cyc);
      end
      prev_valid <= (rx_valid === 1'b1);
      if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if (busy === 1'b1)      busy_cnt <= busy_cnt + 1;
      if (overrun === 1'b1)   ovr_cnt  <= ovr_cnt + 1;
   end

   bit auto_ack  = 0;
   int ack_wait  = 0;
   int ack_edge  = -1;
   int last_start = 0;

   task automatic tick();
      @(negedge CLK);
      if (auto_ack) begin
         if (rx_ack) rx_ack = 1'b0;
         else if (rx_valid) begin
            ack_wait++;
            if (ack_wait == 5) begin rx_ack = 1'b1; ack_wait = 0; end
         end else ack_wait = 0;
      end else if (ack_edge >= 0) begin
         rx_ack = (cyc + 1 == ack_edge);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input bit ack_deliv);
      UART_RX = 1'b0;
      last_start = cyc;
      if (ack_deliv) ack_edge = cyc + 2 + 1 + H + 9*C;
      repeat (C) tick();
      for (int i = 0; i < 8; i++) begin
         UART_RX = b[i];
         repeat (C) tick();
      end
      UART_RX = stop;
      repeat (C) tick();
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      tick();
      rx_ack = 1'b0;
   endtask

   logic [7:0] msg [8] = '{8'h41, 8'h52, 8'h54, 8'h59, 8'h20, 8'h41, 8'h37, 8'h0A};

   initial begin : stim
      int base, fbase, bbase, obase;
      UART_RX = 1'b1;
      RST     = 1'b1;
      rx_ack  = 1'b0;
      repeat (3) tick();
      RST = 1'b0;
      tick();
      chk("reset state", 32'({rx_data, rx_valid, frame_err, overrun, busy}), 32'd0);

      // Single byte: latency and ack
      base = rise_data.size();
      send_byte(8'h41, 1'b1, 0);
      chk("0x41 delivered", 32'(rise_data.size() - base), 32'd1);
      if (rise_data.size() > base) begin
         chk("0x41 rise cycle", 32'(rise_cyc[base]), 32'(last_start + 155));
         chk("0x41 data", 32'(rise_data[base]), 32'h41);
      end
      do_ack();
      chk("valid low after ack", 32'(rx_valid), 32'd0);
      repeat (5) tick();

      // Back-to-back string with prompt acks
      base = rise_data.size(); fbase = ferr_cnt; obase = ovr_cnt;
      auto_ack = 1;
      for (int i = 0; i < 8; i++) send_byte(msg[i], 1'b1, 0);
      repeat (12) tick();
      auto_ack = 0;
      rx_ack = 1'b0;
      chk("string delivery count", 32'(rise_data.size() - base), 32'd8);
      for (int i = 0; i < 8; i++)
         if (base + i < rise_data.size()) chk("string byte", 32'(rise_data[base+i]), 32'(msg[i]));
      chk("string frame_err count", 32'(ferr_cnt - fbase), 32'd0);
      chk("string overrun cycles", 32'(ovr_cnt - obase), 32'd0);

      // Short glitch
      base = rise_data.size(); fbase = ferr_cnt; bbase = busy_cnt;
      UART_RX = 1'b0;
      repeat (5) tick();
      UART_RX = 1'b1;
      repeat (30) tick();
      chk("glitch busy seen", 32'(busy_cnt > bbase), 32'd1);
      chk("glitch busy back low", 32'(busy), 32'd0);
      chk("glitch no delivery", 32'(rise_data.size() - base), 32'd0);
      chk("glitch no frame_err", 32'(ferr_cnt - fbase), 32'd0);

      // Framing error followed by a break
      base = rise_data.size(); fbase = ferr_cnt;
      send_byte(8'h55, 1'b0, 0);
      repeat (40) tick();
      chk("break frame_err pulses", 32'(ferr_cnt - fbase), 32'd1);
      chk("break no delivery", 32'(rise_data.size() - base), 32'd0);
      chk("break still busy", 32'(busy), 32'd1);
      UART_RX = 1'b1;
      repeat (10) tick();
      chk("break released idle", 32'(busy), 32'd0);
      send_byte(8'h41, 1'b1, 0);
      chk("after break delivered", 32'(rise_data.size() - base), 32'd1);
      chk("after break data", 32'(rx_data), 32'h41);
      do_ack();
      repeat (5) tick();

      // Overrun and same-cycle ack
      send_byte(8'h11, 1'b1, 0);
      send_byte(8'h22, 1'b1, 0);
      chk("overrun keeps data", 32'(rx_data), 32'h11);
      chk("overrun set", 32'(overrun), 32'd1);
      do_ack();
      chk("ack clears valid/overrun", 32'({rx_valid, overrun}), 32'd0);
      send_byte(8'h44, 1'b1, 0);
      send_byte(8'h33, 1'b1, 1);
      chk("same-cycle ack data", 32'(rx_data), 32'h33);
      chk("same-cycle ack valid/ovr", 32'({rx_valid, overrun}), 32'b10);
      ack_edge = -1;
      rx_ack = 1'b0;
      repeat (5) tick();

      // Reset during data bit 4 (rx_valid still high from 0x33)
      UART_RX = 1'b0;
      repeat (C) tick();
      for (int i = 0; i < 4; i++) begin
         UART_RX = 1'(8'hA5 >> i);
         repeat (C) tick();
      end
      UART_RX = 1'b0;
      repeat (H) tick();
      RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      UART_RX = 1'b1;
      tick();
      chk("mid-frame reset outputs", 32'({rx_data, rx_valid, frame_err, overrun, busy}), 32'd0);
      repeat (20) tick();
      base = rise_data.size();
      send_byte(8'hA5, 1'b1, 0);
      chk("post-reset delivered", 32'(rise_data.size() - base), 32'd1);
      chk("post-reset data", 32'(rx_data), 32'hA5);
      do_ack();
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
